fir_mac_sched: RTL and testbench
================================

Name: fir_mac_sched

Overview:
- Control sequencer for the complex 29-tap symmetric FIR.
- Gates coefficient loading and pulls samples from the input FIFO.
- Shifts the sample delay line and steps the 5-multiplier datapath through its coefficient phases.
- Tracks the datapath pipeline and raises PushOut when a finished filter output leaves the pipeline; it sits between fifo, the delay line and fir_datapath inside firc.

Parameters:
NCOEF, 15, unique coefficients (14 mirrored + centre), valid CoefAddr 1..NCOEF
NMULT, 5, complex multipliers per cycle in fir_datapath
NPHASE, 3, phases per output = ceil(NCOEF/NMULT)
PIPE_LAT, 3, cycles from last-phase issue to accumulated result valid

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
PushCoef  in  1  coefficient write strobe
CoefAddr  in  5  coefficient address, 1-based
coef_we  out  1  write enable to coefficient store
coef_err  out  1  sticky: PushCoef seen outside LOAD_COEF
fifo_empty  in  1  input FIFO empty (show-ahead data valid when low)
fifo_full  in  1  input FIFO full
fifo_PullOut  out  1  pop one sample from FIFO this cycle
StopIn  out  1  backpressure to sample source
shift_en  out  1  shift popped sample into delay line at this edge
count  out  2  current phase 0..NPHASE-1 to fir_datapath
acc_clr  out  1  datapath accumulator loads instead of adds
acc_en  out  1  datapath accumulator update enable
PushOut  out  1  FI/FQ valid this cycle
busy  out  1  phase issue or pipeline non-empty

Behaviour:
- Reset low (async): state=LOAD_COEF, coef mask=0, count=0, pipeline valid/last shift register=0, coef_err=0. All outputs 0 except StopIn, which follows fifo_full.
- StopIn = fifo_full, combinational, in all states including reset.
- States: LOAD_COEF, WAIT, MAC.
- LOAD_COEF:
  - coef_we = PushCoef && 1<=CoefAddr<=NCOEF, combinational.
  - Each accepted write sets mask[CoefAddr-1]; rewriting an address is allowed.
  - Addr 0 or >NCOEF is ignored: coef_we=0, no mask change, no error.
  - Go to WAIT when mask is all ones and PushCoef=0.
  - The FIFO is never pulled in LOAD_COEF.
- WAIT: if !fifo_empty, assert fifo_PullOut=shift_en=1 this cycle and go to MAC with count=0 next cycle.
- MAC:
  - acc_en=1 every phase; acc_clr=1 only when count=0.
  - count increments each cycle.
  - At count=NPHASE-1, push {valid=1,last=1} into the pipeline; other phases push nothing.
  - At count=NPHASE-1 with !fifo_empty: pull and shift in the same cycle, then count=0 next cycle. The delay line updates at the edge after the last phase reads it, so sustained throughput is 1 output per NPHASE cycles.
  - At count=NPHASE-1 with fifo_empty: go to WAIT.
  - fifo_empty changes during phases 0..NPHASE-2 are ignored.
- Output: PushOut=1 exactly PIPE_LAT cycles after the count=NPHASE-1 cycle, one cycle wide, one per sample. There is no downstream stall: PushOut is never held or dropped.
- busy = (state==MAC) || any pipeline valid bit.
- PushCoef while in WAIT/MAC: coef_we=0, coef_err set, sequencing unaffected. coef_err clears only on reset.
- fifo_PullOut is never asserted when fifo_empty=1.
- Reset mid-MAC: the in-flight output is discarded (no PushOut), coefficients must be reloaded, and the FIFO contents are the FIFO's responsibility.

Test Plan:
1. Release reset, write CoefAddr 1..14 only, then push samples. Required: state stays LOAD_COEF, fifo_PullOut never 1. Then write addr 15, drop PushCoef; WAIT is reached the next cycle.
2. Write addr 0 and 20 during LOAD_COEF. Required: coef_we=0, mask unchanged, coef_err=0.
3. After load, put 1 sample in the FIFO (fifo_empty falls at cycle T). Required:
   - fifo_PullOut=shift_en=1 at T.
   - count=0,1,2 at T+1..T+3, with acc_clr only at T+1.
   - PushOut=1 only at T+6 (PIPE_LAT=3), then WAIT.
4. Keep FIFO non-empty for 10 samples. Required:
   - pulls at T, T+3, T+6, …, T+27 (10 pulls).
   - PushOut at T+6, T+9, …, T+33, exactly 10 pulses.
   - count cycles 0,1,2 with no gaps.
5. Pulse PushCoef with CoefAddr=3 during MAC. Required: coef_we=0, coef_err=1 and stays high, outputs continue unchanged.
6. Assert Reset low at count=1 of a sample. Required: all outputs 0 immediately (asynchronous), no PushOut afterwards, state LOAD_COEF after release.

Source files
------------

// File: rtl/fir_mac_sched_if.sv
// Sequencer-facing signal bundle for fir_mac_sched: coefficient load strobes,
// input FIFO handshake, datapath phase controls and the output-valid pulse.
interface fir_mac_sched_if;
   logic       PushCoef;
   logic [4:0] CoefAddr;
   logic       coef_we;
   logic       coef_err;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_PullOut;
   logic       StopIn;
   logic       shift_en;
   logic [1:0] count;
   logic       acc_clr;
   logic       acc_en;
   logic       PushOut;
   logic       busy;

   // master: the environment around the sequencer (coef source, FIFO, datapath)
   modport master (
      output PushCoef, CoefAddr, fifo_empty, fifo_full,
      input  coef_we, coef_err, fifo_PullOut, StopIn, shift_en,
             count, acc_clr, acc_en, PushOut, busy
   );

   // slave: the sequencer itself
   modport slave (
      input  PushCoef, CoefAddr, fifo_empty, fifo_full,
      output coef_we, coef_err, fifo_PullOut, StopIn, shift_en,
             count, acc_clr, acc_en, PushOut, busy
   );
endinterface

// File: rtl/fir_mac_sched.sv
// Control sequencer for the 29-tap symmetric complex FIR: gates coefficient
// loading, pulls samples, steps the multiplier phases and tracks the pipeline.
module fir_mac_sched #(
   parameter int NCOEF    = 15,
   parameter int NMULT    = 5,
   parameter int NPHASE   = (NCOEF + NMULT - 1) / NMULT,
   parameter int PIPE_LAT = 3
) (
   input logic            Clk,
   input logic            Reset,
   fir_mac_sched_if.slave bus
);

   typedef enum logic [1:0] {LOAD_COEF, WAIT, MAC} state_e;

   localparam logic [1:0] LAST_PH = 2'(NPHASE - 1);

   state_e              state_q;
   logic [NCOEF-1:0]    mask_q;
   logic [1:0]          count_q;
   logic                acc_clr_q;
   logic                acc_en_q;
   logic                coef_err_q;
   logic [PIPE_LAT-1:0] vld_pipe_q;
   logic [PIPE_LAT-1:0] last_pipe_q;

   logic addr_ok, coef_we, last_ph, pull;

   // Combinational strobes are gated by Reset so every output except StopIn
   // drops the moment reset asserts, regardless of PushCoef/fifo_empty.
   always_comb begin
      addr_ok = (bus.CoefAddr != 5'd0) && (bus.CoefAddr <= 5'(NCOEF));
      coef_we = Reset && (state_q == LOAD_COEF) && bus.PushCoef && addr_ok;
      last_ph = (state_q == MAC) && (count_q == LAST_PH);
      pull    = Reset && !bus.fifo_empty && ((state_q == WAIT) || last_ph);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= LOAD_COEF;
         mask_q      <= '0;
         count_q     <= '0;
         acc_clr_q   <= 1'b0;
         acc_en_q    <= 1'b0;
         coef_err_q  <= 1'b0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
      end else begin
         // Only the final phase issues a result into the pipeline.
         vld_pipe_q  <= PIPE_LAT'({vld_pipe_q, last_ph});
         last_pipe_q <= PIPE_LAT'({last_pipe_q, last_ph});
         if (bus.PushCoef && (state_q != LOAD_COEF))
            coef_err_q <= 1'b1;
         case (state_q)
            LOAD_COEF: begin
               for (int i = 0; i < NCOEF; i++)
                  if (coef_we && (bus.CoefAddr == 5'(i + 1)))
                     mask_q[i] <= 1'b1;
               if ((&mask_q) && !bus.PushCoef)
                  state_q <= WAIT;
            end
            WAIT: begin
               if (pull) begin
                  state_q   <= MAC;
                  count_q   <= '0;
                  acc_en_q  <= 1'b1;
                  acc_clr_q <= 1'b1;
               end
            end
            MAC: begin
               if (count_q == LAST_PH) begin
                  count_q <= '0;
                  // Back-to-back sample: the delay line shifts at this edge,
                  // after the last phase has read it.
                  if (pull) begin
                     acc_en_q  <= 1'b1;
                     acc_clr_q <= 1'b1;
                  end else begin
                     state_q   <= WAIT;
                     acc_en_q  <= 1'b0;
                     acc_clr_q <= 1'b0;
                  end
               end else begin
                  count_q   <= count_q + 2'd1;
                  acc_clr_q <= 1'b0;
               end
            end
            default: state_q <= LOAD_COEF;
         endcase
      end
   end

   assign bus.coef_we      = coef_we;
   assign bus.coef_err     = coef_err_q;
   assign bus.fifo_PullOut = pull;
   assign bus.shift_en     = pull;
   assign bus.StopIn       = bus.fifo_full;
   assign bus.count        = count_q;
   assign bus.acc_clr      = acc_clr_q;
   assign bus.acc_en       = acc_en_q;
   assign bus.PushOut      = vld_pipe_q[PIPE_LAT-1] & last_pipe_q[PIPE_LAT-1];
   assign bus.busy         = (state_q == MAC) || (|vld_pipe_q);

endmodule

// File: tb/tb_fir_mac_sched.sv
// Randomized bench for fir_mac_sched: a cycle-indexed schedule model predicts
// every output from when samples are pulled and when coefficients finish.
module tb_fir_mac_sched;
   localparam int NCOEF    = 15;
   localparam int NPHASE   = 3;
   localparam int PIPE_LAT = 3;
   localparam int FDEPTH   = 8;
   localparam int NCYC     = 4096;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   fir_mac_sched_if bus ();

   fir_mac_sched dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   always #5 Clk = ~Clk;

   int n_chk = 0;
   int n_fail = 0;

   // Expected datapath controls per absolute cycle, filled when a pull is predicted.
   int e_cnt  [0:NCYC-1];
   bit e_clr  [0:NCYC-1];
   bit e_en   [0:NCYC-1];
   bit e_push [0:NCYC-1];
   bit e_busy [0:NCYC-1];

   int cyc = 0;
   int fcount = 0;
   bit written [0:NCOEF];
   int wait_start = -1;
   int ready_cyc = 0;
   bit err_m = 0;
   bit rst_active = 1;
   int n_push_obs = 0;
   int n_pull_obs = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit mask_full();
      bit f = 1;
      for (int a = 1; a <= NCOEF; a++) f &= written[a];
      return f;
   endfunction

   // A pull at cycle t occupies phases t+1..t+NPHASE; the result surfaces
   // PIPE_LAT cycles after the last phase.
   task automatic schedule(input int t);
      for (int k = 0; k < NPHASE; k++) begin
         e_cnt[t+1+k] = k;
         e_en[t+1+k]  = 1;
      end
      e_clr[t+1] = 1;
      e_push[t+NPHASE+PIPE_LAT] = 1;
      for (int k = 1; k <= NPHASE + PIPE_LAT; k++) e_busy[t+k] = 1;
   endtask

   task automatic model_reset();
      for (int c = cyc; c < NCYC; c++) begin
         e_cnt[c] = 0; e_clr[c] = 0; e_en[c] = 0; e_push[c] = 0; e_busy[c] = 0;
      end
      for (int a = 0; a <= NCOEF; a++) written[a] = 0;
      wait_start = -1;
      ready_cyc = 0;
      err_m = 0;
   endtask

   task automatic check_outputs(input bit e_pull, input bit e_we, input bit e_err);
      chk("pull",    bus.fifo_PullOut, e_pull);
      chk("shift",   bus.shift_en, e_pull);
      chk("count",   bus.count, e_cnt[cyc]);
      chk("acc_clr", bus.acc_clr, e_clr[cyc]);
      chk("acc_en",  bus.acc_en, e_en[cyc]);
      chk("pushout", bus.PushOut, e_push[cyc]);
      chk("busy",    bus.busy, e_busy[cyc]);
      chk("coef_we", bus.coef_we, e_we);
      chk("coef_err", bus.coef_err, e_err);
      chk("stopin",  bus.StopIn, bus.fifo_full);
   endtask

   // Called just after a rising edge: drive, predict, sample mid-cycle, advance.
   task automatic run_cycle(input bit pc, input logic [4:0] addr, input int nadd);
      bit e_pull, e_we, e_err, in_load, addr_ok;
      fcount = (fcount + nadd > FDEPTH) ? FDEPTH : fcount + nadd;
      bus.PushCoef   = pc;
      bus.CoefAddr   = addr;
      bus.fifo_empty = (fcount == 0);
      bus.fifo_full  = (fcount == FDEPTH);
      addr_ok = (addr >= 5'd1) && (addr <= 5'(NCOEF));
      in_load = (wait_start < 0) || (cyc < wait_start);
      e_err = err_m;
      e_pull = 0;
      e_we = 0;
      if (rst_active) e_err = 0;
      else begin
         e_pull = !in_load && (cyc >= ready_cyc) && (fcount > 0);
         e_we   = pc && in_load && addr_ok;
         if (in_load && !pc && mask_full()) begin
            wait_start = cyc + 1;
            ready_cyc  = cyc + 1;
         end
         if (e_we) written[addr] = 1;
         if (pc && !in_load) err_m = 1;
         if (e_pull) begin
            ready_cyc = cyc + NPHASE;
            schedule(cyc);
         end
      end
      #4;
      check_outputs(e_pull, e_we, e_err);
      if (bus.PushOut) n_push_obs++;
      if (bus.fifo_PullOut) n_pull_obs++;
      if (e_pull) fcount--;
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   initial begin
      int order [0:13];
      int guard;
      bus.PushCoef = 0; bus.CoefAddr = 0; bus.fifo_empty = 1; bus.fifo_full = 0;
      @(posedge Clk); #1;

      // Reset held: strobes must stay low even with PushCoef and data present.
      fcount = FDEPTH - 1;
      for (int i = 0; i < 3; i++) run_cycle(1, 5'd3, 1);
      Reset = 1'b1;
      rst_active = 0;

      // Invalid addresses are ignored without error.
      run_cycle(1, 5'd0, 0);
      run_cycle(1, 5'd20, 0);

      // Addresses 1..14 in shuffled order plus a rewrite; FIFO holds data.
      for (int i = 0; i < 14; i++) order[i] = i + 1;
      for (int i = 13; i > 0; i--) begin
         int j, t;
         j = $urandom_range(0, i);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      foreach (order[i]) run_cycle(1, 5'(order[i]), 0);
      run_cycle(1, 5'd5, 0);
      n_pull_obs = 0;
      for (int i = 0; i < 5; i++) run_cycle(0, 5'd0, 0);
      chk("no_pull_partial", n_pull_obs, 0);
      run_cycle(1, 5'd15, 0);
      run_cycle(0, 5'd0, 0);
      n_pull_obs = 0;
      run_cycle(0, 5'd0, 0);
      chk("wait_next_cycle", n_pull_obs, 1);
      while (fcount > 0 && cyc < 200) run_cycle(0, 5'd0, 0);
      for (int i = 0; i < 10; i++) run_cycle(0, 5'd0, 0);

      // Single sample.
      n_push_obs = 0; n_pull_obs = 0;
      run_cycle(0, 5'd0, 1);
      for (int i = 0; i < 10; i++) run_cycle(0, 5'd0, 0);
      chk("single_pulls", n_pull_obs, 1);
      chk("single_pushes", n_push_obs, 1);

      // Ten samples streaming.
      n_push_obs = 0; n_pull_obs = 0;
      for (int i = 0; i < 10; i++) run_cycle(0, 5'd0, 1);
      for (int i = 0; i < 30; i++) run_cycle(0, 5'd0, 0);
      chk("stream_pulls", n_pull_obs, 10);
      chk("stream_pushes", n_push_obs, 10);

      // PushCoef during MAC raises the sticky error only.
      run_cycle(0, 5'd0, 2);
      run_cycle(1, 5'd3, 0);
      for (int i = 0; i < 8; i++) run_cycle(0, 5'd0, 0);

      // Random traffic with occasional stray coefficient writes.
      for (int i = 0; i < 300; i++)
         run_cycle(($urandom_range(0, 19) == 0), 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0) ? 1 : 0);

      // Reset asserted at phase 1 of a sample.
      guard = 0;
      while (!(e_en[cyc] && e_cnt[cyc] == 1) && guard < 50) begin
         run_cycle(0, 5'd0, 1);
         guard++;
      end
      chk("rst_find", guard < 50, 1);
      bus.PushCoef = 0;
      #1 Reset = 1'b0;
      rst_active = 1;
      model_reset();
      #1;
      chk("rst_async_count",   bus.count, 0);
      chk("rst_async_acc_en",  bus.acc_en, 0);
      chk("rst_async_busy",    bus.busy, 0);
      chk("rst_async_pull",    bus.fifo_PullOut, 0);
      chk("rst_async_err",     bus.coef_err, 0);
      chk("rst_async_stopin",  bus.StopIn, bus.fifo_full);
      @(posedge Clk); #1; cyc++;
      for (int i = 0; i < 3; i++) run_cycle(0, 5'd0, 1);
      Reset = 1'b1;
      rst_active = 0;
      n_push_obs = 0; n_pull_obs = 0;
      for (int i = 0; i < 15; i++) run_cycle(0, 5'd0, 1);
      chk("post_rst_pushes", n_push_obs, 0);
      chk("post_rst_pulls",  n_pull_obs, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
